// File: rtl/mips_register_file.sv
// Architectural register file for the MIPS pipeline: R1..R31 plus HI/LO.
// R0 reads as zero and has no storage. One decoded write port from WB,
// two combinational read ports to ID with write-through bypass so a read
// in the same cycle as a write to that register returns the new data.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   WB_RF_ENABLE        GPR write enable
//   WB_DEST_REG         GPR write address (writes to 0 are discarded)
//   WB_DATA             GPR write data
//   WB_HI_ENABLE/DATA   HI write port
//   WB_LO_ENABLE/DATA   LO write port
//   RA, RB              read addresses (rs, rt)
//   PA, PB              read data, bypassed
//   HI_OUT, LO_OUT      HI/LO data, bypassed
module mips_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WB_RF_ENABLE,
  input  logic [ADDR_WIDTH-1:0] WB_DEST_REG,
  input  logic [DATA_WIDTH-1:0] WB_DATA,
  input  logic                  WB_HI_ENABLE,
  input  logic                  WB_LO_ENABLE,
  input  logic [DATA_WIDTH-1:0] WB_HI_DATA,
  input  logic [DATA_WIDTH-1:0] WB_LO_DATA,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  output logic [DATA_WIDTH-1:0] PA,
  output logic [DATA_WIDTH-1:0] PB,
  output logic [DATA_WIDTH-1:0] HI_OUT,
  output logic [DATA_WIDTH-1:0] LO_OUT
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [NUM_REGS-1:1]   wr_sel;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic                  byp_a;
  logic                  byp_b;

  // One-hot write decode; slot 0 does not exist, so R0 writes fall away.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      wr_sel[i] = WB_RF_ENABLE && (WB_DEST_REG == ADDR_WIDTH'(i));
    end
  end

  // Register storage; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (wr_sel[i]) begin
          regs[i] <= WB_DATA;
        end
      end
      if (WB_HI_ENABLE) begin
        hi_q <= WB_HI_DATA;
      end
      if (WB_LO_ENABLE) begin
        lo_q <= WB_LO_DATA;
      end
    end
  end

  // Stored-value read select; address 0 yields zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      if (RA == ADDR_WIDTH'(i)) begin
        rd_a = regs[i];
      end
      if (RB == ADDR_WIDTH'(i)) begin
        rd_b = regs[i];
      end
    end
  end

  // Bypass only for a live, non-zero-destination write outside reset.
  always_comb begin
    byp_a = WB_RF_ENABLE && !reset && (WB_DEST_REG != '0) && (RA == WB_DEST_REG);
    byp_b = WB_RF_ENABLE && !reset && (WB_DEST_REG != '0) && (RB == WB_DEST_REG);
  end

  assign PA     = byp_a ? WB_DATA : rd_a;
  assign PB     = byp_b ? WB_DATA : rd_b;
  assign HI_OUT = (WB_HI_ENABLE && !reset) ? WB_HI_DATA : hi_q;
  assign LO_OUT = (WB_LO_ENABLE && !reset) ? WB_LO_DATA : lo_q;

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: reset, write/read, R0, bypass,
// HI/LO and reset-over-write priority.
module tb_mips_register_file;

  logic        clk;
  logic        reset;
  logic        WB_RF_ENABLE;
  logic [4:0]  WB_DEST_REG;
  logic [31:0] WB_DATA;
  logic        WB_HI_ENABLE;
  logic        WB_LO_ENABLE;
  logic [31:0] WB_HI_DATA;
  logic [31:0] WB_LO_DATA;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [31:0] PA;
  logic [31:0] PB;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  int checks = 0;
  int errors = 0;

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .WB_RF_ENABLE (WB_RF_ENABLE),
    .WB_DEST_REG  (WB_DEST_REG),
    .WB_DATA      (WB_DATA),
    .WB_HI_ENABLE (WB_HI_ENABLE),
    .WB_LO_ENABLE (WB_LO_ENABLE),
    .WB_HI_DATA   (WB_HI_DATA),
    .WB_LO_DATA   (WB_LO_DATA),
    .RA           (RA),
    .RB           (RB),
    .PA           (PA),
    .PB           (PB),
    .HI_OUT       (HI_OUT),
    .LO_OUT       (LO_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge to a stable sampling point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; WB_RF_ENABLE = 1'b0; WB_DEST_REG = '0; WB_DATA = '0;
    WB_HI_ENABLE = 1'b0; WB_LO_ENABLE = 1'b0; WB_HI_DATA = '0; WB_LO_DATA = '0;
    RA = 5'd0; RB = 5'd0;
    tick();
    RA = 5'd5; RB = 5'd31;
    #1;
    check("rst_pa", PA, 32'h0);
    check("rst_pb", PB, 32'h0);
    check("rst_hi", HI_OUT, 32'h0);
    check("rst_lo", LO_OUT, 32'h0);
    reset = 1'b0;
    tick();

    // Write R5 and HI, then reset clears them.
    WB_RF_ENABLE = 1'b1; WB_DEST_REG = 5'd5; WB_DATA = 32'hDEADBEEF;
    WB_HI_ENABLE = 1'b1; WB_HI_DATA = 32'h77; RA = 5'd5;
    #1;
    check("r5_bypass", PA, 32'hDEADBEEF);
    check("hi_bypass77", HI_OUT, 32'h77);
    tick();
    WB_RF_ENABLE = 1'b0; WB_HI_ENABLE = 1'b0;
    #1;
    check("r5_stored", PA, 32'hDEADBEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("r5_after_rst", PA, 32'h0);
    check("hi_after_rst", HI_OUT, 32'h0);
    check("lo_after_rst", LO_OUT, 32'h0);

    // Write then read R7; R8 untouched.
    WB_RF_ENABLE = 1'b1; WB_DEST_REG = 5'd7; WB_DATA = 32'h12345678;
    tick();
    WB_RF_ENABLE = 1'b0; WB_DATA = 32'hCAFEF00D; RA = 5'd7; RB = 5'd8;
    #1;
    check("r7_read", PA, 32'h12345678);
    check("r8_zero", PB, 32'h0);
    tick();
    check("r7_no_en_hold", PA, 32'h12345678);

    // R0 stays zero during and after a write to it.
    WB_RF_ENABLE = 1'b1; WB_DEST_REG = 5'd0; WB_DATA = 32'hFFFFFFFF; RA = 5'd0; RB = 5'd0;
    #1;
    check("r0_pa_during", PA, 32'h0);
    check("r0_pb_during", PB, 32'h0);
    tick();
    WB_RF_ENABLE = 1'b0;
    #1;
    check("r0_pa_after", PA, 32'h0);
    check("r0_pb_after", PB, 32'h0);
    RA = 5'd7;
    #1;
    check("r0_write_no_alias", PA, 32'h12345678);

    // Bypass on both ports for R9.
    WB_RF_ENABLE = 1'b1; WB_DEST_REG = 5'd9; WB_DATA = 32'h1;
    tick();
    WB_RF_ENABLE = 1'b0; RA = 5'd9; RB = 5'd9;
    #1;
    check("r9_old", PA, 32'h1);
    WB_RF_ENABLE = 1'b1; WB_DATA = 32'hA5A5A5A5;
    #1;
    check("r9_byp_pa", PA, 32'hA5A5A5A5);
    check("r9_byp_pb", PB, 32'hA5A5A5A5);
    tick();
    WB_RF_ENABLE = 1'b0;
    #1;
    check("r9_st_pa", PA, 32'hA5A5A5A5);
    check("r9_st_pb", PB, 32'hA5A5A5A5);

    // HI/LO together, then LO alone.
    WB_HI_ENABLE = 1'b1; WB_HI_DATA = 32'h1111; WB_LO_ENABLE = 1'b1; WB_LO_DATA = 32'h2222;
    #1;
    check("hi_byp", HI_OUT, 32'h1111);
    check("lo_byp", LO_OUT, 32'h2222);
    tick();
    WB_HI_ENABLE = 1'b0; WB_LO_ENABLE = 1'b0; WB_HI_DATA = 32'h9999; WB_LO_DATA = 32'h8888;
    #1;
    check("hi_st", HI_OUT, 32'h1111);
    check("lo_st", LO_OUT, 32'h2222);
    WB_LO_ENABLE = 1'b1; WB_LO_DATA = 32'h3333;
    #1;
    check("hi_keep", HI_OUT, 32'h1111);
    check("lo_byp2", LO_OUT, 32'h3333);
    tick();
    WB_LO_ENABLE = 1'b0;
    #1;
    check("hi_keep2", HI_OUT, 32'h1111);
    check("lo_st2", LO_OUT, 32'h3333);
    check("gpr_unaffected", PA, 32'hA5A5A5A5);

    // Reset beats a same-cycle write to R3; contents from before are lost.
    reset = 1'b1; WB_RF_ENABLE = 1'b1; WB_DEST_REG = 5'd3; WB_DATA = 32'h55;
    WB_HI_ENABLE = 1'b1; WB_HI_DATA = 32'h4444; RA = 5'd3; RB = 5'd7;
    #1;
    check("rst_no_byp_pa", PA, 32'h0);
    check("rst_no_byp_hi", HI_OUT, 32'h1111);
    tick();
    reset = 1'b0; WB_RF_ENABLE = 1'b0; WB_HI_ENABLE = 1'b0;
    #1;
    check("rst_prio_pa", PA, 32'h0);
    check("rst_lost_r7", PB, 32'h0);
    check("rst_prio_hi", HI_OUT, 32'h0);
    check("rst_lost_lo", LO_OUT, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
